// File: rtl/itp_capture_ctrl.sv
// itp_capture_ctrl: decimated centre-crop capture of the pixel stream into a planar R/G/B tensor buffer.
// Define ITP_PINGPONG_EN to alternate between two buffers (o_wr_addr[16] / o_buf_sel).
module itp_capture_ctrl #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int H_ITP_START = 128,
  parameter int V_ITP_START = 48,
  parameter int ITP_RANGE   = 384,
  parameter int DECIM       = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_pix_valid,
  input  logic [9:0]  i_Red,
  input  logic [9:0]  i_Green,
  input  logic [9:0]  i_Blue,
  input  logic        i_capture_req,
  output logic        o_busy,
  output logic        o_wr_en,
  output logic [16:0] o_wr_addr,
  output logic [9:0]  o_wr_data,
  output logic        o_done,
  output logic        o_short_frame,
  output logic        o_buf_sel
);
  localparam int         OUT_DIM  = ITP_RANGE / DECIM;
  localparam logic [9:0] X_LAST   = 10'(H_ACT - 1);
  localparam logic [9:0] X_LO     = 10'(H_ITP_START);
  localparam logic [9:0] X_HI     = 10'(H_ITP_START + ITP_RANGE);
  localparam logic [8:0] Y_LAST   = 9'(V_ACT - 1);
  localparam logic [8:0] Y_LO     = 9'(V_ITP_START);
  localparam logic [8:0] Y_HI     = 9'(V_ITP_START + ITP_RANGE);
  localparam logic [1:0] PH_LAST  = 2'(DECIM - 1);
  localparam logic [6:0] IDX_LAST = 7'(OUT_DIM - 1);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [9:0] x_q, cur_x, g_q, b_q;
  logic [8:0] y_q, cur_y;
  logic [1:0] px_q, py_q, cur_px, cur_py, cnt;
  logic [6:0] col_q, row_q, cur_col, cur_row;
  logic [13:0] rc_q;
  logic x_in, y_in, eol, eof, cap, kept, last_wr, flush, issue, buf_bit, short_q;
  // A frame start overrides the tracked position for the pixel arriving in the same cycle.
  always_comb begin
    cur_x   = i_frame_start ? '0 : x_q;
    cur_y   = i_frame_start ? '0 : y_q;
    cur_px  = i_frame_start ? '0 : px_q;
    cur_py  = i_frame_start ? '0 : py_q;
    cur_col = i_frame_start ? '0 : col_q;
    cur_row = i_frame_start ? '0 : row_q;
    x_in    = cur_x >= X_LO && cur_x < X_HI;
    y_in    = cur_y >= Y_LO && cur_y < Y_HI;
    eol     = cur_x == X_LAST;
    eof     = eol && cur_y == Y_LAST;
    cap     = state == CAPTURE || (state == ARMED && i_frame_start);
    kept    = cap && i_pix_valid && x_in && y_in && cur_px == 2'd0 && cur_py == 2'd0;
    last_wr = state == CAPTURE && o_wr_en && o_wr_addr[15:14] == 2'd2 && o_wr_addr[13:0] == {IDX_LAST, IDX_LAST};
    flush   = state == CAPTURE && i_frame_start && !last_wr;
    issue   = kept || (cnt != 2'd0 && !flush);
    nxt     = (state == IDLE && i_capture_req) ? ARMED :
              (state == ARMED && i_frame_start) ? CAPTURE :
              last_wr ? DONE :
              state == DONE ? IDLE : state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      px_q  <= '0;
      py_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (i_pix_valid) begin
      x_q   <= eol ? '0 : cur_x + 10'd1;
      px_q  <= eol ? '0 : x_in ? (cur_px == PH_LAST ? '0 : cur_px + 2'd1) : cur_px;
      col_q <= eol ? '0 : (x_in && cur_px == PH_LAST) ? cur_col + 7'd1 : cur_col;
      y_q   <= eof ? '0 : eol ? cur_y + 9'd1 : cur_y;
      py_q  <= eof ? '0 : (eol && y_in) ? (cur_py == PH_LAST ? '0 : cur_py + 2'd1) : cur_py;
      row_q <= eof ? '0 : (eol && y_in && cur_py == PH_LAST) ? cur_row + 7'd1 : cur_row;
    end else if (i_frame_start) begin
      x_q   <= '0;
      y_q   <= '0;
      px_q  <= '0;
      py_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end
  // cnt: 0 = no pending write, 1 = G next, 2 = B next
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      cnt       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      rc_q      <= '0;
      short_q   <= 1'b0;
    end else begin
      o_wr_en <= issue;
      cnt     <= kept ? 2'd1 : (!flush && cnt == 2'd1) ? 2'd2 : 2'd0;
      short_q <= flush;
      if (kept) begin
        g_q  <= i_Green;
        b_q  <= i_Blue;
        rc_q <= {cur_row, cur_col};
      end
      if (issue) begin
        o_wr_data <= kept ? i_Red : cnt == 2'd1 ? g_q : b_q;
        o_wr_addr <= {buf_bit, kept ? 2'd0 : cnt, kept ? {cur_row, cur_col} : rc_q};
      end
    end
`ifdef ITP_PINGPONG_EN
  logic buf_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) buf_q <= 1'b0;
    else buf_q <= buf_q ^ last_wr;
  assign buf_bit   = ~buf_q;
  assign o_buf_sel = buf_q;
`else
  assign buf_bit   = 1'b0;
  assign o_buf_sel = 1'b0;
`endif
  assign o_busy        = state == ARMED || state == CAPTURE;
  assign o_done        = state == DONE;
  assign o_short_frame = short_q;
endmodule
